debounce_multi: RTL and testbench

- N-channel successor to the single-input debouncer, for buttons and switches on the ECP5 boards.
- Each channel has an input synchroniser, a sample-tick stability filter, and registered rise/fall strobes.
- Adds behaviour the single-channel block lacks: long-press detection and optional auto-repeat.
- Sits between raw board pins and user logic; all outputs are in the clk domain.

---
 rtl/debounce_multi.sv | 126 ++++++++++++
 tb/tb_debounce_multi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// N-channel button/switch debouncer: 2-FF synchroniser, tick-sampled stability
// filter, rise/fall strobes, long-press detection and optional auto-repeat.
module debounce_multi #(
  parameter int N      = 4,
  parameter int D      = 6,
  parameter int L      = 8,
  parameter int LONG   = 64,
  parameter int REPEAT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_in,
  output logic [N-1:0] o_db,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall,
  output logic [N-1:0] o_long_press,
  output logic [N-1:0] o_repeat
);

  localparam int              CW       = $clog2(L + 1);
  localparam logic [CW-1:0]   STAB_END = CW'(L - 1);
  localparam logic [15:0]     LONG_V   = 16'(LONG);
  localparam logic [15:0]     HOLD_MAX = 16'hFFFF;

  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;
  logic         w_tick;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
    end
  end

  // Shared sample tick: one clock in every 2^D.
  generate
    if (D == 0) begin : g_tick_every
      assign w_tick = 1'b1;
    end else begin : g_tick_div
      logic [D-1:0] r_tick_cnt;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_tick_cnt <= '0;
        else          r_tick_cnt <= r_tick_cnt + D'(1);
      end
      assign w_tick = &r_tick_cnt;
    end
  endgenerate

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [CW-1:0] r_stab;
    logic [15:0]   r_hold;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic          r_lp;
    logic          w_flip;
    logic          w_db_next;
    logic          w_hold_inc;
    logic          w_lp_hit;

    assign w_flip     = w_tick && (r_sync2[g] != r_db) && (r_stab == STAB_END);
    assign w_db_next  = r_db ^ w_flip;
    // Hold only advances while db was and stays high, so the release tick is silent.
    assign w_hold_inc = w_tick && r_db && w_db_next;
    assign w_lp_hit   = w_hold_inc && (r_hold == LONG_V - 16'd1);

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_stab <= '0;
        r_hold <= '0;
        r_db   <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_lp   <= 1'b0;
      end else begin
        if (w_tick) begin
          if ((r_sync2[g] == r_db) || w_flip) r_stab <= '0;
          else                                r_stab <= r_stab + CW'(1);
        end
        r_db   <= w_db_next;
        r_rise <= w_flip && !r_db;
        r_fall <= w_flip && r_db;
        r_lp   <= w_lp_hit;
        if (!w_db_next)                             r_hold <= '0;
        else if (w_hold_inc && (r_hold != HOLD_MAX)) r_hold <= r_hold + 16'd1;
      end
    end

    if (REPEAT > 0) begin : g_rep
      localparam int            RW       = $clog2(REPEAT + 1);
      localparam logic [RW-1:0] REP_END  = RW'(REPEAT - 1);
      logic [RW-1:0] r_rep_cnt;
      logic          r_rep;
      logic          w_rep_step;

      // Runs off its own modulo counter so repeat continues once r_hold saturates.
      assign w_rep_step = w_hold_inc && (r_hold >= LONG_V);

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_rep_cnt <= '0;
          r_rep     <= 1'b0;
        end else begin
          r_rep <= w_rep_step && (r_rep_cnt == REP_END);
          if (!w_db_next || w_lp_hit)
            r_rep_cnt <= '0;
          else if (w_rep_step)
            r_rep_cnt <= (r_rep_cnt == REP_END) ? '0 : r_rep_cnt + RW'(1);
        end
      end
      assign o_repeat[g] = r_rep;
    end else begin : g_no_rep
      assign o_repeat[g] = 1'b0;
    end

    assign o_db[g]         = r_db;
    assign o_rise[g]       = r_rise;
    assign o_fall[g]       = r_fall;
    assign o_long_press[g] = r_lp;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: tick-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed timing expectations.
module tb_debounce_multi;

  localparam int N    = 4;
  localparam int D    = 2;
  localparam int L    = 4;
  localparam int LONG = 8;
  localparam int REP  = 4;
  localparam int TP   = 1 << D;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in_r;
  logic [N-1:0] o_db, o_rise, o_fall, o_lp, o_rp;
  logic [N-1:0] z_db, z_rise, z_fall, z_lp, z_rp;

  debounce_multi #(.N(N), .D(D), .L(L), .LONG(LONG), .REPEAT(REP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_r),
    .o_db(o_db), .o_rise(o_rise), .o_fall(o_fall),
    .o_long_press(o_lp), .o_repeat(o_rp)
  );

  debounce_multi #(.N(N), .D(D), .L(L), .LONG(LONG), .REPEAT(0)) dut_norep (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_r),
    .o_db(z_db), .o_rise(z_rise), .o_fall(z_fall),
    .o_long_press(z_lp), .o_repeat(z_rp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc_g = 0;
  bit chk_en = 1'b0;

  task automatic chk_v(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d..%0d", nm, $time, act, lo, hi);
    end
  endtask

  // Model: sampled inputs pass through two stages, tick = every TP-th clock since reset,
  // db flips after L disagreeing ticks in a row, hold counts ticks spent high.
  logic [N-1:0] m_s1, m_s2, m_db, m_rise, m_fall, m_lp, m_rp;
  int           m_cyc;
  int           m_run  [N];
  int           m_held [N];

  initial begin
    bit   tk;
    logic was_high;
    forever begin
      @(posedge clk);
      cyc_g++;
      if (!rst_n) begin
        m_cyc = 0;
        m_s1 = '0; m_s2 = '0; m_db = '0;
        m_rise = '0; m_fall = '0; m_lp = '0; m_rp = '0;
        for (int c = 0; c < N; c++) begin
          m_run[c] = 0;
          m_held[c] = 0;
        end
      end else begin
        tk = ((m_cyc % TP) == TP - 1);
        m_cyc++;
        m_rise = '0; m_fall = '0; m_lp = '0; m_rp = '0;
        for (int c = 0; c < N; c++) begin
          was_high = m_db[c];
          if (tk) begin
            if (m_s2[c] != m_db[c]) begin
              m_run[c]++;
              if (m_run[c] == L) begin
                m_db[c] = ~m_db[c];
                m_run[c] = 0;
                if (m_db[c]) m_rise[c] = 1'b1;
                else         m_fall[c] = 1'b1;
              end
            end else begin
              m_run[c] = 0;
            end
          end
          if (!m_db[c]) begin
            m_held[c] = 0;
          end else if (tk && was_high) begin
            m_held[c]++;
            if (m_held[c] == LONG) m_lp[c] = 1'b1;
            if (m_held[c] > LONG && ((m_held[c] - LONG) % REP) == 0) m_rp[c] = 1'b1;
          end
        end
        m_s2 = m_s1;
        m_s1 = in_r;
      end
    end
  end

  // Event log of the DUT strobes: index 0 rise, 1 fall, 2 long_press, 3 repeat.
  int ev_cnt   [4][N];
  int ev_first [4][N];
  int ev0_cnt  [4][N];
  logic [N-1:0] mv  [4];
  logic [N-1:0] mv0 [4];

  task automatic clr();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < N; c++) begin
        ev_cnt[k][c] = 0;
        ev_first[k][c] = -1;
        ev0_cnt[k][c] = 0;
      end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk_v("db",       o_db,   m_db);
        chk_v("rise",     o_rise, m_rise);
        chk_v("fall",     o_fall, m_fall);
        chk_v("long",     o_lp,   m_lp);
        chk_v("repeat",   o_rp,   m_rp);
        chk_v("nr_db",    z_db,   m_db);
        chk_v("nr_rise",  z_rise, m_rise);
        chk_v("nr_fall",  z_fall, m_fall);
        chk_v("nr_long",  z_lp,   m_lp);
        chk_v("nr_repeat", z_rp,  '0);
        mv[0] = o_rise; mv[1] = o_fall; mv[2] = o_lp; mv[3] = o_rp;
        mv0[0] = z_rise; mv0[1] = z_fall; mv0[2] = z_lp; mv0[3] = z_rp;
        for (int k = 0; k < 4; k++)
          for (int c = 0; c < N; c++) begin
            if (mv[k][c]) begin
              ev_cnt[k][c]++;
              if (ev_first[k][c] < 0) ev_first[k][c] = cyc_g;
            end
            if (mv0[k][c]) ev0_cnt[k][c]++;
          end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int t0, t_rel, t_r;

  initial begin
    rst_n = 1'b0;
    in_r  = '0;
    clr();
    step(3);
    chk_en = 1'b1;
    chk_v("rst_db",   o_db,   4'b0000);
    chk_v("rst_rise", o_rise, 4'b0000);
    chk_v("rst_fall", o_fall, 4'b0000);
    chk_v("rst_long", o_lp,   4'b0000);
    chk_v("rst_rep",  o_rp,   4'b0000);
    rst_n = 1'b1;
    step(5);

    // Clean press on channel 0
    clr();
    t0 = cyc_g;
    in_r[0] = 1'b1;
    step(200);
    chk_i("t1_rise_cnt", ev_cnt[0][0], 1);
    chk_rng("t1_rise_lat", ev_first[0][0] - t0, 15, 18);
    chk_v("t1_db", o_db, 4'b0001);
    chk_i("t1_long_dly", ev_first[2][0] - ev_first[0][0], 32);
    chk_i("t1_rep_first", ev_first[3][0] - ev_first[0][0], 48);
    chk_i("t1_nr_long_cnt", ev0_cnt[2][0], 1);
    chk_i("t1_nr_rep_cnt", ev0_cnt[3][0], 0);
    in_r[0] = 1'b0;
    step(40);
    chk_v("t1_db_rel", o_db, 4'b0000);

    // Bounce on channel 1
    clr();
    for (int k = 0; k < 10; k++) begin
      in_r[1] = ~in_r[1];
      step(6);
    end
    chk_i("t2_bounce_rise", ev_cnt[0][1], 0);
    chk_i("t2_bounce_fall", ev_cnt[1][1], 0);
    t0 = cyc_g;
    in_r[1] = 1'b1;
    step(40);
    chk_i("t2_rise_cnt", ev_cnt[0][1], 1);
    chk_i("t2_fall_cnt", ev_cnt[1][1], 0);
    chk_rng("t2_rise_lat", ev_first[0][1] - t0, 15, 18);
    in_r[1] = 1'b0;
    step(40);

    // Long press with repeat on channel 2, 40 ticks
    clr();
    t0 = cyc_g;
    in_r[2] = 1'b1;
    step(160);
    in_r[2] = 1'b0;
    t_rel = cyc_g;
    step(40);
    chk_rng("t3_rise_lat", ev_first[0][2] - t0, 15, 18);
    chk_i("t3_long_cnt", ev_cnt[2][2], 1);
    chk_i("t3_long_dly", ev_first[2][2] - ev_first[0][2], 32);
    chk_i("t3_rep_first", ev_first[3][2] - ev_first[0][2], 48);
    chk_i("t3_rep_cnt", ev_cnt[3][2], 7);
    chk_i("t3_fall_dly", ev_first[1][2] - ev_first[0][2], 160);
    chk_rng("t3_fall_lat", ev_first[1][2] - t_rel, 15, 18);

    // Simultaneous press/release on channels 0 and 3
    clr();
    t0 = cyc_g;
    in_r[0] = 1'b1;
    in_r[3] = 1'b1;
    step(60);
    in_r[0] = 1'b0;
    in_r[3] = 1'b0;
    step(40);
    chk_rng("t4_rise_lat", ev_first[0][0] - t0, 15, 18);
    chk_i("t4_rise_same", ev_first[0][3], ev_first[0][0]);
    chk_i("t4_fall_same", ev_first[1][3], ev_first[1][0]);
    chk_i("t4_rise3_cnt", ev_cnt[0][3], 1);
    chk_i("t4_fall3_cnt", ev_cnt[1][3], 1);

    // Reset in the middle of a long hold on channel 2
    clr();
    in_r[2] = 1'b1;
    step(60);
    chk_i("t5_long_pre", ev_cnt[2][2], 1);
    rst_n = 1'b0;
    step(1);
    t_r = cyc_g;
    chk_v("t5_rst_db",   o_db,   4'b0000);
    chk_v("t5_rst_rise", o_rise, 4'b0000);
    chk_v("t5_rst_long", o_lp,   4'b0000);
    chk_v("t5_rst_rep",  o_rp,   4'b0000);
    rst_n = 1'b1;
    clr();
    step(1);
    chk_v("t5_post_rise", o_rise, 4'b0000);
    chk_v("t5_post_fall", o_fall, 4'b0000);
    step(60);
    chk_i("t5_rise_lat", ev_first[0][2] - t_r, 16);
    chk_i("t5_long_dly", ev_first[2][2] - ev_first[0][2], 32);
    in_r[2] = 1'b0;
    step(40);
    chk_v("t5_db_end", o_db, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
